outrow_check: RTL

Downstream sink stage for the core complex. It consumes the 11-bit values the bottom row of cores writes through its four down ports and compares each value against a per-lane expected stream. It maintains the `correct`/`count` result counters that the top-level bench and board display. This is the output-side mirror of the input-row stream source: expected streams come from the same stream memory image, lanes 4..7.

---
 rtl/tis_pkg.sv | 28 ++
 rtl/outlane.sv | 90 +++++++++
 rtl/outrow_check.sv | 84 ++++++++
 3 files changed

// File: rtl/tis_pkg.sv
// Shared definitions for the core-complex stream blocks: word and length types,
// the sink-lane state encoding and the saturating counter helper.
package tis_pkg;

   localparam int W      = 11;
   localparam int MAXLEN = 39;

   typedef logic signed [W-1:0] word_t;
   typedef logic [5:0]          len_t;

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      ACK  = 2'd1,
      FULL = 2'd2
   } lane_state_t;

   // Result counters stick at all-ones instead of wrapping.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum_v;
      sum_v = {1'b0, a} + {1'b0, b};
      if (sum_v[8]) begin
         return 8'hFF;
      end else begin
         return sum_v[7:0];
      end
   endfunction

endpackage

// File: rtl/outlane.sv
// One sink lane: accepts a value from its down port every other cycle, compares it
// against the lane's expected stream and stops for good once the stream is complete.
module outlane
   import tis_pkg::*;
#(
   parameter int W      = 11,
   parameter int MAXLEN = 39
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  len_t                     length,
   input  logic [MAXLEN-1:0][W-1:0] data,
   input  logic                     wready,
   input  logic [W-1:0]             down,
   output logic                     read,
   output logic                     hit,
   output logic                     miss,
   output logic                     full
);

   localparam len_t MAXLEN_L = len_t'(MAXLEN);

   lane_state_t state_r;
   lane_state_t next_s;
   len_t        idx_r;
   len_t        idx_next_s;
   len_t        sel_s;
   logic        read_r;
   logic        accept_s;
   logic        match_s;

   // Next-state, index advance and accept/compare decision.
   always_comb begin
      next_s     = state_r;
      idx_next_s = idx_r;
      accept_s   = 1'b0;
      if (idx_r < MAXLEN_L) begin
         sel_s = idx_r;
      end else begin
         sel_s = 6'd0;
      end
      match_s = ($signed(down) == $signed(data[sel_s]));
      case (state_r)
         WAIT: begin
            if (wready && (idx_r < length)) begin
               accept_s   = 1'b1;
               next_s     = ACK;
               idx_next_s = idx_r + 6'd1;
            end else begin
               next_s = WAIT;
            end
         end
         ACK: begin
            // idx already points past the value just taken
            if (idx_r == length) begin
               next_s = FULL;
            end else begin
               next_s = WAIT;
            end
         end
         FULL: begin
            next_s = FULL;
         end
         default: begin
            next_s = WAIT;
         end
      endcase
   end

   // Lane state, index and read strobe registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= (length == 6'd0) ? FULL : WAIT;
         idx_r   <= 6'd0;
         read_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         idx_r   <= idx_next_s;
         read_r  <= accept_s;
      end
   end

   // Hit/miss are qualified by the accepting edge so the counters land on that edge.
   assign hit  = accept_s & match_s;
   assign miss = accept_s & ~match_s;
   assign read = read_r;
   assign full = (state_r == FULL);

endmodule

// File: rtl/outrow_check.sv
// Output-row sink: one checking lane per down port plus the saturating
// correct/count/errors tallies and the all-lanes-complete flag.
module outrow_check
   import tis_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int W      = 11,
   parameter int MAXLEN = 39
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [LANES-1:0][5:0]          length,
   input  logic [LANES*MAXLEN-1:0][W-1:0] data,
   input  logic [LANES-1:0]               wready,
   input  logic [LANES-1:0][W-1:0]        down,
   output logic [LANES-1:0]               read,
   output logic [7:0]                     correct,
   output logic [7:0]                     count,
   output logic [7:0]                     errors,
   output logic                           done
);

   logic [LANES-1:0] hit_s;
   logic [LANES-1:0] miss_s;
   logic [LANES-1:0] full_s;
   logic [7:0]       nhit_s;
   logic [7:0]       nmiss_s;
   logic [7:0]       nacc_s;
   logic [7:0]       correct_r;
   logic [7:0]       count_r;
   logic [7:0]       errors_r;
   logic             done_r;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      outlane #(
         .W      (W),
         .MAXLEN (MAXLEN)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .length (length[i]),
         .data   (data[i*MAXLEN +: MAXLEN]),
         .wready (wready[i]),
         .down   (down[i]),
         .read   (read[i]),
         .hit    (hit_s[i]),
         .miss   (miss_s[i]),
         .full   (full_s[i])
      );
   end

   // Population counts of this edge's hits and misses across all lanes.
   always_comb begin
      nhit_s  = 8'd0;
      nmiss_s = 8'd0;
      for (int i = 0; i < LANES; i++) begin
         nhit_s  = nhit_s + {7'd0, hit_s[i]};
         nmiss_s = nmiss_s + {7'd0, miss_s[i]};
      end
      nacc_s = nhit_s + nmiss_s;
   end

   // Saturating result counters and the registered completion flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         correct_r <= 8'd0;
         count_r   <= 8'd0;
         errors_r  <= 8'd0;
         done_r    <= 1'b0;
      end else begin
         correct_r <= sat_add8(correct_r, nhit_s);
         count_r   <= sat_add8(count_r, nacc_s);
         errors_r  <= sat_add8(errors_r, nmiss_s);
         done_r    <= &full_s;
      end
   end

   assign correct = correct_r;
   assign count   = count_r;
   assign errors  = errors_r;
   assign done    = done_r;

endmodule
